// File: rtl/alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer
//
// Hardwired control unit for the single-bus datapath. It runs instruction
// fetch in T0-T2, decodes the IR, and then runs the execute states T3-T6 for
// register-to-register ALU, MUL/DIV, NEG/NOT, NOP and HALT instructions.
//
// Every strobe is a register. Each cycle the block works out the next state
// and the strobe pattern that goes with it, and it loads both on the same
// edge. As a result the outputs are a pure function of the state register,
// they are valid for the whole cycle, and the datapath acts on them at the
// following posedge.
//
// The instruction fields (op, ra, rb, rc) are captured on the edge that
// enters T3. From that point the execute states use the captured copy, so
// the ir input only has to hold the new instruction on that edge.
//
// Ports
//   clock        system clock; all state changes on posedge
//   clear        synchronous, active-low reset (forces IDLE, all strobes 0)
//   run          start / continue request, sampled in IDLE and at the last
//                execute state of an instruction
//   mem_ready    memory data valid this cycle; a low value stalls T1
//   ir           instruction: [31:27] op, [26:23] ra, [22:19] rb, [18:15] rc
//   PCout, ZLOout, ZHIout, MDRout          bus drivers
//   PCin, MARin, MDRin, IRin, Yin,
//   Zlowin, Zhighin, HIin, LOin            register loads
//   read         memory read strobe
//   IncPC        ALU PC+1 select
//   Rout / Rin   one-hot general register bus drive / load (NREG wide)
//   operation    ALU operation select (OPW wide)
//   done         one-cycle pulse in the last execute state
//   illegal      one-cycle pulse in T3 for an undefined opcode
//   halted       level, high while in HALTED
// -----------------------------------------------------------------------------
module alu_control_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            ZLOout,
  output logic            ZHIout,
  output logic            MDRout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            HIin,
  output logic            LOin,
  output logic            read,
  output logic            IncPC,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [OPW-1:0]  operation,
  output logic            done,
  output logic            illegal,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  // The instruction class decides the shape of the execute sequence.
  typedef enum logic [2:0] {
    C_ALU, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
  } class_t;

  state_t     state_reg, state_next;
  class_t     cls_reg, cls_next;
  logic [4:0] op_reg, op_next;
  logic [3:0] ra_reg, ra_next;
  logic [3:0] rb_reg, rb_next;
  logic [3:0] rc_reg, rc_next;

  logic            pc_out_next, zlo_out_next, zhi_out_next, mdr_out_next;
  logic            pc_in_next, mar_in_next, mdr_in_next, ir_in_next, y_in_next;
  logic            zlow_in_next, zhigh_in_next, hi_in_next, lo_in_next;
  logic            read_next, inc_pc_next;
  logic [NREG-1:0] rout_next, rin_next;
  logic [OPW-1:0]  operation_next;
  logic            done_next, illegal_next, halted_next;

  // The low instruction bits carry no control information.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:0];

  function automatic class_t classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: classify = C_ALU;
      5'b01111, 5'b10000:                     classify = C_MULDIV;
      5'b10001, 5'b10010:                     classify = C_UNARY;
      5'b11010:                               classify = C_NOP;
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_ILLEGAL;
    endcase
  endfunction

  // One-hot register select. An index beyond the register file decodes to
  // all-zero, so it neither drives the bus nor writes a register.
  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Next-state logic and field capture.
  always_comb begin
    state_next = state_reg;
    cls_next   = cls_reg;
    op_next    = op_reg;
    ra_next    = ra_reg;
    rb_next    = rb_reg;
    rc_next    = rc_reg;
    case (state_reg)
      S_IDLE: if (run) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   if (mem_ready) state_next = S_T2;
      S_T2: begin
        // IR holds the new instruction from here on; latch what execute needs.
        state_next = S_T3;
        op_next    = ir[31:27];
        ra_next    = ir[26:23];
        rb_next    = ir[22:19];
        rc_next    = ir[18:15];
        cls_next   = classify(ir[31:27]);
      end
      S_T3: begin
        case (cls_reg)
          C_ALU, C_MULDIV, C_UNARY: state_next = S_T4;
          C_HALT:                   state_next = S_HALTED;
          default:                  state_next = run ? S_T0 : S_IDLE;
        endcase
      end
      S_T4:     state_next = S_T5;
      S_T5: begin
        if (cls_reg == C_MULDIV) state_next = S_T6;
        else                     state_next = run ? S_T0 : S_IDLE;
      end
      S_T6:     state_next = run ? S_T0 : S_IDLE;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  // Strobe pattern for the state being entered. It is registered together
  // with that state, so the outputs follow the state register exactly.
  always_comb begin
    pc_out_next    = 1'b0;
    zlo_out_next   = 1'b0;
    zhi_out_next   = 1'b0;
    mdr_out_next   = 1'b0;
    pc_in_next     = 1'b0;
    mar_in_next    = 1'b0;
    mdr_in_next    = 1'b0;
    ir_in_next     = 1'b0;
    y_in_next      = 1'b0;
    zlow_in_next   = 1'b0;
    zhigh_in_next  = 1'b0;
    hi_in_next     = 1'b0;
    lo_in_next     = 1'b0;
    read_next      = 1'b0;
    inc_pc_next    = 1'b0;
    rout_next      = '0;
    rin_next       = '0;
    operation_next = '0;
    done_next      = 1'b0;
    illegal_next   = 1'b0;
    halted_next    = 1'b0;
    case (state_next)
      S_T0: begin
        pc_out_next  = 1'b1;
        mar_in_next  = 1'b1;
        inc_pc_next  = 1'b1;
        zlow_in_next = 1'b1;
      end
      S_T1: begin
        zlo_out_next = 1'b1;
        read_next    = 1'b1;
        mdr_in_next  = 1'b1;
        // Load PC only on the first T1 cycle, so that a memory stall
        // advances PC only once.
        pc_in_next   = (state_reg == S_T0);
      end
      S_T2: begin
        mdr_out_next = 1'b1;
        ir_in_next   = 1'b1;
      end
      S_T3: begin
        case (cls_next)
          C_ALU: begin
            rout_next = reg_sel(rb_next);
            y_in_next = 1'b1;
          end
          C_MULDIV: begin
            rout_next = reg_sel(ra_next);
            y_in_next = 1'b1;
          end
          C_UNARY: ; // single-operand ops need no Y operand
          C_NOP, C_HALT: done_next = 1'b1;
          default: begin
            illegal_next = 1'b1;
            done_next    = 1'b1;
          end
        endcase
      end
      S_T4: begin
        operation_next = OPW'(op_next);
        zlow_in_next   = 1'b1;
        case (cls_next)
          C_ALU:    rout_next = reg_sel(rc_next);
          C_MULDIV: begin
            rout_next     = reg_sel(rb_next);
            zhigh_in_next = 1'b1;
          end
          default:  rout_next = reg_sel(rb_next);
        endcase
      end
      S_T5: begin
        operation_next = OPW'(op_next);
        zlo_out_next   = 1'b1;
        if (cls_next == C_MULDIV) begin
          lo_in_next = 1'b1;
        end else begin
          rin_next  = reg_sel(ra_next);
          done_next = 1'b1;
        end
      end
      S_T6: begin
        operation_next = OPW'(op_next);
        zhi_out_next   = 1'b1;
        hi_in_next     = 1'b1;
        done_next      = 1'b1;
      end
      S_HALTED: halted_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg <= S_IDLE;
      cls_reg   <= C_NOP;
      op_reg    <= '0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
      PCout     <= 1'b0;
      ZLOout    <= 1'b0;
      ZHIout    <= 1'b0;
      MDRout    <= 1'b0;
      PCin      <= 1'b0;
      MARin     <= 1'b0;
      MDRin     <= 1'b0;
      IRin      <= 1'b0;
      Yin       <= 1'b0;
      Zlowin    <= 1'b0;
      Zhighin   <= 1'b0;
      HIin      <= 1'b0;
      LOin      <= 1'b0;
      read      <= 1'b0;
      IncPC     <= 1'b0;
      Rout      <= '0;
      Rin       <= '0;
      operation <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cls_reg   <= cls_next;
      op_reg    <= op_next;
      ra_reg    <= ra_next;
      rb_reg    <= rb_next;
      rc_reg    <= rc_next;
      PCout     <= pc_out_next;
      ZLOout    <= zlo_out_next;
      ZHIout    <= zhi_out_next;
      MDRout    <= mdr_out_next;
      PCin      <= pc_in_next;
      MARin     <= mar_in_next;
      MDRin     <= mdr_in_next;
      IRin      <= ir_in_next;
      Yin       <= y_in_next;
      Zlowin    <= zlow_in_next;
      Zhighin   <= zhigh_in_next;
      HIin      <= hi_in_next;
      LOin      <= lo_in_next;
      read      <= read_next;
      IncPC     <= inc_pc_next;
      Rout      <= rout_next;
      Rin       <= rin_next;
      operation <= operation_next;
      done      <= done_next;
      illegal   <= illegal_next;
      halted    <= halted_next;
    end
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_control_sequencer
//
// For each instruction the reference model lists the complete strobe pattern
// of every cycle from T0 onward. It builds that list from the instruction
// class, the register fields and the number of memory stalls. A separate rule
// gives the expected cycle count from T0 to done. The bench prints one line
// per instruction.
// -----------------------------------------------------------------------------
module tb_alu_control_sequencer;

  localparam int NREG = 16;
  localparam int OPW  = 5;

  logic            clock = 1'b0;
  logic            clear, run, mem_ready;
  logic [31:0]     ir;
  logic            PCout, ZLOout, ZHIout, MDRout;
  logic            PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin;
  logic            read, IncPC;
  logic [NREG-1:0] Rout, Rin;
  logic [OPW-1:0]  operation;
  logic            done, illegal, halted;

  typedef struct packed {
    logic        pcout, zloout, zhiout, mdrout;
    logic        pcin, marin, mdrin, irin, yin, zlowin, zhighin, hiin, loin;
    logic        read, incpc;
    logic [15:0] rout, rin;
    logic [4:0]  operation;
    logic        done, illegal, halted;
  } outs_t;

  int    passed = 0;
  int    total  = 0;
  outs_t exp_q[$];
  outs_t zero_outs = '0;
  logic [4:0] legal_ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};

  alu_control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .read(read), .IncPC(IncPC), .Rout(Rout), .Rin(Rin),
    .operation(operation), .done(done), .illegal(illegal), .halted(halted)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic outs_t sample();
    outs_t s;
    s = '0;
    s.pcout = PCout;   s.zloout = ZLOout;  s.zhiout = ZHIout;  s.mdrout = MDRout;
    s.pcin = PCin;     s.marin = MARin;    s.mdrin = MDRin;    s.irin = IRin;
    s.yin = Yin;       s.zlowin = Zlowin;  s.zhighin = Zhighin;
    s.hiin = HIin;     s.loin = LOin;      s.read = read;      s.incpc = IncPC;
    s.rout = Rout;     s.rin = Rin;        s.operation = operation;
    s.done = done;     s.illegal = illegal; s.halted = halted;
    return s;
  endfunction

  task automatic check(input string tag, input outs_t want);
    outs_t obs;
    obs = sample();
    total = total + 1;
    assert (obs === want) passed = passed + 1;
    else $error("FAIL %s: observed %h required %h", tag, obs, want);
  endtask

  task automatic check_int(input string tag, input int obs, input int want);
    total = total + 1;
    assert (obs == want) passed = passed + 1;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, want);
  endtask

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  // Cycles from T0 through done, inclusive.
  function automatic int latency(input logic [4:0] op, input int stalls);
    if (op >= 5'd3 && op <= 5'd11) return 6 + stalls;
    if (op == 5'd17 || op == 5'd18) return 6 + stalls;
    if (op == 5'd15 || op == 5'd16) return 7 + stalls;
    return 4 + stalls;
  endfunction

  // Reference model: the strobe pattern of every cycle of one instruction.
  task automatic push_expected(input logic [31:0] instr, input int stalls);
    outs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; exp_q.push_back(e);
    for (int k = 0; k <= stalls; k++) begin
      e = '0; e.zloout = 1; e.read = 1; e.mdrin = 1; e.pcin = (k == 0);
      exp_q.push_back(e);
    end
    e = '0; e.mdrout = 1; e.irin = 1; exp_q.push_back(e);
    if (op >= 5'd3 && op <= 5'd11) begin
      e = '0; e.rout = oh(rb); e.yin = 1; exp_q.push_back(e);
      e = '0; e.rout = oh(rc); e.operation = op; e.zlowin = 1; exp_q.push_back(e);
      e = '0; e.zloout = 1; e.rin = oh(ra); e.operation = op; e.done = 1; exp_q.push_back(e);
    end else if (op == 5'd15 || op == 5'd16) begin
      e = '0; e.rout = oh(ra); e.yin = 1; exp_q.push_back(e);
      e = '0; e.rout = oh(rb); e.operation = op; e.zlowin = 1; e.zhighin = 1; exp_q.push_back(e);
      e = '0; e.zloout = 1; e.loin = 1; e.operation = op; exp_q.push_back(e);
      e = '0; e.zhiout = 1; e.hiin = 1; e.operation = op; e.done = 1; exp_q.push_back(e);
    end else if (op == 5'd17 || op == 5'd18) begin
      e = '0; exp_q.push_back(e);
      e = '0; e.rout = oh(rb); e.operation = op; e.zlowin = 1; exp_q.push_back(e);
      e = '0; e.zloout = 1; e.rin = oh(ra); e.operation = op; e.done = 1; exp_q.push_back(e);
    end else begin
      e = '0; e.done = 1; e.illegal = !(op == 5'd26 || op == 5'd27); exp_q.push_back(e);
    end
  endtask

  // Runs one instruction. The DUT must be in IDLE or in the done cycle of
  // the previous instruction. run is random except in the done cycle.
  task automatic do_instr(input string tag, input logic [31:0] instr,
                          input int stalls, input logic run_after);
    int n;
    int done_at;
    exp_q.delete();
    push_expected(instr, stalls);
    n = exp_q.size();
    ir = instr;
    run = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    done_at = -1;
    for (int j = 0; j < n; j++) begin
      @(posedge clock); #1;
      if (done === 1'b1 && done_at < 0) done_at = j;
      check($sformatf("%s_c%0d", tag, j), exp_q.pop_front());
      if (j >= 1 && j <= stalls) mem_ready = 1'b0;
      else if (j == stalls + 1)  mem_ready = 1'b1;
      else                       mem_ready = 1'($urandom_range(0, 1));
      run = (j == n - 1) ? run_after : 1'($urandom_range(0, 1));
    end
    check_int($sformatf("%s_latency", tag), done_at + 1, latency(instr[31:27], stalls));
    $display("instr %-10s ir=%08h stalls=%0d cycles=%0d run_after=%0d",
             tag, instr, stalls, n, run_after);
  endtask

  task automatic idle_cycles(input string tag, input int count);
    for (int j = 0; j < count; j++) begin
      @(posedge clock); #1;
      check(tag, zero_outs);
    end
  endtask

  initial begin
    outs_t e;
    logic [4:0] op;
    int stalls;
    logic ra_bit;

    // Reset, with run held high to confirm that clear wins.
    clear = 1'b0; run = 1'b1; mem_ready = 1'b0; ir = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset", zero_outs);
    clear = 1'b1; run = 1'b0;
    idle_cycles("idle_after_reset", 2);

    // ADD R0,R4,R5: without a stall, then with three stall cycles.
    do_instr("add", 32'h18228000, 0, 1'b0);
    idle_cycles("idle_after_add", 1);
    do_instr("add_stall", 32'h18228000, 3, 1'b1);
    do_instr("mul", {5'b01111, 4'd2, 4'd3, 4'd0, 15'd0}, 0, 1'b1);
    do_instr("div", {5'b10000, 4'd9, 4'd14, 4'd1, 15'd0}, 1, 1'b1);
    do_instr("illegal", {5'b11111, 27'h0123456}, 0, 1'b1);
    do_instr("nop", {5'd26, 27'd0}, 2, 1'b1);
    do_instr("neg", {5'd17, 4'd7, 4'd9, 4'd0, 15'd0}, 0, 1'b0);
    idle_cycles("idle_after_neg", 1);

    // Reset during T4 of an ADD: the writeback must never appear.
    exp_q.delete();
    push_expected(32'h18228000, 0);
    ir = 32'h18228000; run = 1'b1; mem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clock); #1;
      check($sformatf("abort_c%0d", j), exp_q.pop_front());
    end
    clear = 1'b0;
    @(posedge clock); #1;
    check("abort_cleared", zero_outs);
    clear = 1'b1;
    do_instr("restart", 32'h18228000, 0, 1'b1);

    // Random instructions chained back to back or separated by idle cycles.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 13)];
      else                           op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      stalls = int'($urandom_range(0, 3));
      ra_bit = 1'($urandom_range(0, 1));
      do_instr($sformatf("rnd%0d", t), {op, 27'($urandom)}, stalls, ra_bit);
      if (!ra_bit) idle_cycles($sformatf("rnd%0d_idle", t), int'($urandom_range(1, 2)));
    end

    // HALT: run held high does not restart it; only clear exits.
    do_instr("halt", {5'd27, 27'd0}, 0, 1'b1);
    e = '0; e.halted = 1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clock); #1;
      check($sformatf("halted_%0d", j), e);
    end
    clear = 1'b0;
    @(posedge clock); #1;
    check("halt_cleared", zero_outs);
    clear = 1'b1; run = 1'b0;
    idle_cycles("idle_after_halt", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
